fetch_sequencer: RTL and testbench

Instruction fetch/sequencing front end for the 8-bit lab core. Owns the program counter, fetches 9-bit instructions from instruction memory over a request/valid handshake, splits them into the opcode and operand fields the ALU consumes, and hands them to execute over a valid/ready handshake. It is the consumer of the ALU's branch outcome (`branch_taken`, target from `aluOut`) and redirects the PC accordingly.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_sequencer_if.sv | 40 ++++
 rtl/fetch_sequencer_fields.sv | 29 ++
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared opcodes, states and field layout
// for the fetch/sequencing front end.
package fetch_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 9;

  localparam logic [3:0] OP_EQ0  = 4'b0101;
  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam int OPC_HI = 8;
  localparam int OPC_LO = 5;
  localparam int RS1_HI = 4;
  localparam int RS1_LO = 2;
  localparam int FLD_HI = 1;
  localparam int FLD_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_BR,
    S_HALTED
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: imem, decode and branch handshakes
// master = sequencer side, slave = memory/execute side.
interface fetch_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9
);

  logic               imem_req_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic               imem_valid_i;
  logic [INSTR_W-1:0] imem_data_i;
  logic               dec_valid_o;
  logic               dec_ready_i;
  logic [3:0]         opcode_o;
  logic [2:0]         rs1_o;
  logic [1:0]         field_o;
  logic [PC_W-1:0]    pc_o;
  logic               br_valid_i;
  logic               br_taken_i;
  logic [PC_W-1:0]    br_target_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_valid_i, imem_data_i,
    output dec_valid_o, opcode_o, rs1_o,
    output field_o, pc_o,
    input  dec_ready_i,
    input  br_valid_i, br_taken_i, br_target_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_valid_i, imem_data_i,
    input  dec_valid_o, opcode_o, rs1_o,
    input  field_o, pc_o,
    output dec_ready_i,
    output br_valid_i, br_taken_i, br_target_i
  );

endinterface

// File: rtl/fetch_sequencer_fields.sv
// instr_fields: slices an instruction and flags control flow.
// Halt decode only exists when FETCH_HALT_EN is defined.
module instr_fields
  import fetch_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [2:0]         rs1,
  output logic [1:0]         field,
  output logic               is_branch,
  output logic               is_halt
);

  assign opcode = instr[OPC_HI:OPC_LO];
  assign rs1    = instr[RS1_HI:RS1_LO];
  assign field  = instr[FLD_HI:FLD_LO];

  assign is_branch = (opcode == OP_EQ0) ||
                     (opcode == OP_JMP);

`ifdef FETCH_HALT_EN
  assign is_halt = (opcode == OP_HALT);
`else
  assign is_halt = 1'b0;
`endif

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner, imem fetch, decode issue, redirect.
// FETCH_HALT_EN enables opcode 4'b1110 as HALT.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [PC_W-1:0]  start_addr_i,
  fetch_sequencer_if.master bus,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] issue_cnt_o
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_inc, dec_pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_q, req_d;
  logic               dv_q, dv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               is_branch, is_halt;
  logic               start_ok, fetch_hs;
  logic               issue_hs, br_hs;

  instr_fields #(
    .INSTR_W (INSTR_W)
  ) u_fields (
    .instr     (instr_q),
    .opcode    (bus.opcode_o),
    .rs1       (bus.rs1_o),
    .field     (bus.field_o),
    .is_branch (is_branch),
    .is_halt   (is_halt)
  );

  assign pc_inc   = pc_q + PC_W'(1);
  assign start_ok = start_i &&
                    (state_q == S_IDLE ||
                     state_q == S_HALTED);
  assign fetch_hs = (state_q == S_FETCH) &&
                    bus.imem_valid_i;
  assign issue_hs = (state_q == S_ISSUE) &&
                    bus.dec_ready_i;
  assign br_hs    = (state_q == S_WAIT_BR) &&
                    bus.br_valid_i;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_valid_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.dec_ready_i) begin
          if (is_branch)    state_d = S_WAIT_BR;
          else if (is_halt) state_d = S_HALTED;
          else              state_d = S_FETCH;
        end
      end
      S_WAIT_BR: begin
        if (bus.br_valid_i) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below.
  always_comb begin
    req_d  = (state_d == S_FETCH);
    dv_d   = (state_d == S_ISSUE);
    busy_d = (state_d == S_FETCH) ||
             (state_d == S_ISSUE) ||
             (state_d == S_WAIT_BR);
`ifdef FETCH_HALT_EN
    done_d = (state_d == S_HALTED);
`else
    done_d = 1'b0;
`endif
  end

  // Registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= 1'b0;
      dv_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      dv_q   <= dv_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // PC, latched instruction and issue counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= '0;
      dec_pc_q <= '0;
      instr_q  <= '0;
      cnt_q    <= '0;
    end else begin
      if (start_ok) begin
        pc_q  <= start_addr_i;
        cnt_q <= '0;
      end
      if (fetch_hs) begin
        instr_q  <= bus.imem_data_i;
        dec_pc_q <= pc_q;
      end
      if (issue_hs) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        if (!is_branch && !is_halt) pc_q <= pc_inc;
      end
      if (br_hs) begin
        pc_q <= bus.br_taken_i ?
                bus.br_target_i : pc_inc;
      end
    end
  end

  assign bus.imem_req_o  = req_q;
  assign bus.imem_addr_o = pc_q;
  assign bus.dec_valid_o = dv_q;
  assign bus.pc_o        = dec_pc_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign issue_cnt_o     = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors for fetch_sequencer.
// Halt checks follow FETCH_HALT_EN like the design.
module tb_fetch_sequencer;

  localparam logic [8:0] I_ADD  = 9'b0000_001_10;
  localparam logic [8:0] I_NOP  = 9'b1111_111_11;
  localparam logic [8:0] I_JMP  = 9'b1011_000_00;
  localparam logic [8:0] I_EQ0  = 9'b0101_010_11;
  localparam logic [8:0] I_HALT = 9'b1110_000_00;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic [7:0]  start_addr_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] issue_cnt_o;

  int n_chk;
  int n_pass;
  int exp_cnt;
  logic [7:0] next_a;

  fetch_sequencer_if #(.PC_W(8), .INSTR_W(9)) bus ();

  fetch_sequencer #(
    .PC_W    (8),
    .INSTR_W (9),
    .CNT_W   (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .bus          (bus),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .issue_cnt_o  (issue_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_req"},   32'(bus.imem_req_o), 0);
    check({pfx, "_addr"},  32'(bus.imem_addr_o), 0);
    check({pfx, "_dv"},    32'(bus.dec_valid_o), 0);
    check({pfx, "_opc"},   32'(bus.opcode_o), 0);
    check({pfx, "_rs1"},   32'(bus.rs1_o), 0);
    check({pfx, "_fld"},   32'(bus.field_o), 0);
    check({pfx, "_pc"},    32'(bus.pc_o), 0);
    check({pfx, "_busy"},  32'(busy_o), 0);
    check({pfx, "_done"},  32'(done_o), 0);
    check({pfx, "_cnt"},   32'(issue_cnt_o), 0);
  endtask

  task automatic fetch_at(input logic [7:0] a,
                          input logic [8:0] ins);
    check("fetch_req",  32'(bus.imem_req_o), 1);
    check("fetch_addr", 32'(bus.imem_addr_o), 32'(a));
    check("fetch_busy", 32'(busy_o), 1);
    bus.imem_valid_i = 1'b1;
    bus.imem_data_i  = ins;
    @(negedge clk);
    bus.imem_valid_i = 1'b0;
    bus.imem_data_i  = '0;
    check("issue_dv",  32'(bus.dec_valid_o), 1);
    check("issue_req", 32'(bus.imem_req_o), 0);
    check("issue_opc", 32'(bus.opcode_o), 32'(ins[8:5]));
    check("issue_rs1", 32'(bus.rs1_o), 32'(ins[4:2]));
    check("issue_fld", 32'(bus.field_o), 32'(ins[1:0]));
    check("issue_pc",  32'(bus.pc_o), 32'(a));
  endtask

  task automatic accept();
    bus.dec_ready_i = 1'b1;
    @(negedge clk);
    bus.dec_ready_i = 1'b0;
    exp_cnt++;
    check("cnt",     32'(issue_cnt_o), 32'(exp_cnt));
    check("dv_drop", 32'(bus.dec_valid_o), 0);
  endtask

  task automatic branch(input int wcyc,
                        input logic tk,
                        input logic [7:0] tgt,
                        input logic [7:0] nxt);
    for (int i = 0; i < wcyc; i++) begin
      check("wait_req",  32'(bus.imem_req_o), 0);
      check("wait_busy", 32'(busy_o), 1);
      bus.imem_valid_i = 1'b1;
      @(negedge clk);
    end
    bus.imem_valid_i = 1'b0;
    bus.br_valid_i   = 1'b1;
    bus.br_taken_i   = tk;
    bus.br_target_i  = tgt;
    @(negedge clk);
    bus.br_valid_i  = 1'b0;
    bus.br_taken_i  = 1'b0;
    bus.br_target_i = '0;
    check("br_req",  32'(bus.imem_req_o), 1);
    check("br_addr", 32'(bus.imem_addr_o), 32'(nxt));
  endtask

  task automatic do_start(input logic [7:0] a);
    start_i      = 1'b1;
    start_addr_i = a;
    @(negedge clk);
    start_i      = 1'b0;
    start_addr_i = '0;
    exp_cnt      = 0;
    check("start_cnt", 32'(issue_cnt_o), 0);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    exp_cnt = 0;
    reset_n = 1'b0;
    start_i = 1'b0;
    start_addr_i     = '0;
    bus.imem_valid_i = 1'b0;
    bus.imem_data_i  = '0;
    bus.dec_ready_i  = 1'b0;
    bus.br_valid_i   = 1'b0;
    bus.br_taken_i   = 1'b0;
    bus.br_target_i  = '0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_req", 32'(bus.imem_req_o), 0);

    do_start(8'h10);
    fetch_at(8'h10, I_ADD); accept();
    fetch_at(8'h11, I_NOP); accept();
    fetch_at(8'h12, I_ADD); accept();

    fetch_at(8'h13, I_EQ0);
    for (int i = 0; i < 5; i++) begin
      check("stall_dv",  32'(bus.dec_valid_o), 1);
      check("stall_opc", 32'(bus.opcode_o), 4'b0101);
      check("stall_fld", 32'(bus.field_o), 2'd3);
      check("stall_pc",  32'(bus.pc_o), 8'h13);
      check("stall_req", 32'(bus.imem_req_o), 0);
      @(negedge clk);
    end
    accept();
    branch(1, 1'b1, 8'h14, 8'h14);

    fetch_at(8'h14, I_JMP); accept();
    branch(2, 1'b1, 8'h20, 8'h20);
    fetch_at(8'h20, I_JMP); accept();
    branch(3, 1'b1, 8'h25, 8'h25);
    fetch_at(8'h25, I_JMP); accept();
    branch(1, 1'b1, 8'h30, 8'h30);
    fetch_at(8'h30, I_EQ0); accept();
    branch(2, 1'b0, 8'h55, 8'h31);
    fetch_at(8'h31, I_JMP); accept();
    branch(0, 1'b1, 8'hFF, 8'hFF);
    fetch_at(8'hFF, I_ADD); accept();
    fetch_at(8'h00, I_JMP); accept();
    branch(0, 1'b1, 8'h05, 8'h05);
    fetch_at(8'h05, I_HALT); accept();

`ifdef FETCH_HALT_EN
    for (int i = 0; i < 3; i++) begin
      check("halt_done", 32'(done_o), 1);
      check("halt_busy", 32'(busy_o), 0);
      check("halt_req",  32'(bus.imem_req_o), 0);
      @(negedge clk);
    end
    do_start(8'h40);
    check("restart_done", 32'(done_o), 0);
    fetch_at(8'h40, I_ADD); accept();
    next_a = 8'h41;
`else
    check("nohalt_done", 32'(done_o), 0);
    fetch_at(8'h06, I_ADD); accept();
    next_a = 8'h07;
`endif

    fetch_at(next_a, I_JMP); accept();
    check("wb_busy", 32'(busy_o), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("async");
    bus.br_valid_i  = 1'b1;
    bus.br_taken_i  = 1'b1;
    bus.br_target_i = 8'h99;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.br_valid_i  = 1'b0;
    bus.br_taken_i  = 1'b0;
    bus.br_target_i = '0;
    check("post_req",  32'(bus.imem_req_o), 0);
    check("post_busy", 32'(busy_o), 0);
    check("post_addr", 32'(bus.imem_addr_o), 0);

    do_start(8'h50);
    start_i      = 1'b1;
    start_addr_i = 8'h77;
    @(negedge clk);
    start_i      = 1'b0;
    start_addr_i = '0;
    check("ign_start_cnt", 32'(issue_cnt_o), 0);
    fetch_at(8'h50, I_ADD); accept();
    check("last_req",  32'(bus.imem_req_o), 1);
    check("last_addr", 32'(bus.imem_addr_o), 8'h51);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
